uart_transmitter_cfg: RTL

Next-generation UART transmitter for the io_circuits UART path. It adds a runtime baud divisor, a parametrised data width, runtime parity and stop-bit selection, and an internal TX FIFO so that software or MMIO writes can queue bytes without stalling. It drives serial_out directly, and its status outputs feed the MMIO status register.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_transmitter_cfg_fifo.sv | 47 ++++
 rtl/uart_transmitter_cfg.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the configurable UART transmitter: parity selection,
// framer states and the minimum usable bit period.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/uart_transmitter_cfg_fifo.sv
// TX queue: synchronous FIFO with wrap pointers carrying an extra MSB so
// full and empty are distinguishable. Read data is presented combinationally.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter_cfg.sv
// Configurable UART transmitter: queued bytes are framed with a runtime
// divisor, parity and stop-bit count latched at the moment each byte is popped.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (0)
// DATA   | data bits, LSB first
// PARITY | optional parity bit
// STOP   | one or two stop bits (1)
module uart_transmitter_cfg import uart_pkg::*; #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 1085
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  input  logic [DIV_WIDTH-1:0]          cfg_divisor,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          serial_out
);

  localparam int BW = $clog2(DATA_WIDTH);
  // Only seeds the latched divisor out of reset; every frame reloads it at pop.
  localparam logic [DIV_WIDTH-1:0] RESET_DIV = DIV_WIDTH'(DEFAULT_DIV);

  tx_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]  clk_cnt_q, clk_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop2_q, stop2_d;
  logic                  serial_d;
  logic                  ready_en_q;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  push, load, bit_end;

  assign data_in_ready = ready_en_q && !fifo_full;
  assign push          = data_in_valid && data_in_ready;
  assign tx_busy       = (state_q != IDLE) || !fifo_empty;
  assign bit_end       = (clk_cnt_q == div_q - DIV_WIDTH'(1));

  uart_tx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (load),
    .din     (data_in),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = bit_end ? '0 : clk_cnt_q + DIV_WIDTH'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    serial_d  = serial_out;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        serial_d  = 1'b1;
        load      = !fifo_empty;
      end
      START: if (bit_end) begin
        state_d   = DATA;
        bit_cnt_d = '0;
        serial_d  = shift_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_cnt_q == BW'(DATA_WIDTH-1)) begin
          if (par_en_q) begin
            state_d  = PARITY;
            serial_d = par_bit_q;
          end else begin
            state_d   = STOP;
            bit_cnt_d = '0;
            serial_d  = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          shift_d   = shift_q >> 1;
          serial_d  = shift_q[1];
        end
      end
      PARITY: if (bit_end) begin
        state_d   = STOP;
        bit_cnt_d = '0;
        serial_d  = 1'b1;
      end
      STOP: if (bit_end) begin
        if (bit_cnt_q == BW'(stop2_q)) begin
          load = !fifo_empty;
          if (fifo_empty) begin
            state_d  = IDLE;
            serial_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop always starts a fresh frame with the configuration seen right now.
    if (load) begin
      state_d   = START;
      clk_cnt_d = '0;
      serial_d  = 1'b0;
      shift_d   = fifo_dout;
      div_d     = (cfg_divisor < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : cfg_divisor;
      par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
      par_bit_d = (^fifo_dout) ^ (cfg_parity == PAR_ODD);
      stop2_d   = cfg_stop2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      div_q      <= RESET_DIV;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      serial_out <= 1'b1;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      serial_out <= serial_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule
